id_stage_reg: RTL and testbench
===============================

ID_STAGE_REG -- requirements
Module: id_stage_reg

Interface
- REQ-001: Clock and reset SHALL be: one clock; reset is asynchronous and active-low.
- REQ-002: clk  in  1  sole clock; all state updates on rising edge.
- REQ-003: rst  in  1  asynchronous, active-low reset.
- REQ-004: flush  in  1  taken-branch flush from EXE; replaces the captured decode with a bubble.
- REQ-005: freeze  in  1  pipeline hold (memory wait / hazard); all registers keep their value.
- REQ-006: WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, B_in, S_in  in  1 each  control bits from ID_Stage.
- REQ-007: EXE_CMD_in  in  4  ALU command.
- REQ-008: PC_in, Val_Rn_in, Val_Rm_in  in  32 each  next-PC and register-operand values.
- REQ-009: imm_in  in  1; Shift_operand_in  in  12; Signed_imm_24_in  in  24; Dest_in, src1_in, src2_in  in  4 each; SR_in  in  4 (NZCV).
- REQ-010: Each *_in SHALL have a matching registered *_out output of the same width.
- REQ-011: valid_out  out  1  slot holds a real instruction (not reset/flush bubble).
- REQ-012: flush_cnt  out  16  saturating count of flushes actually applied.

Function
- REQ-013: Per-edge priority SHALL be: reset > freeze > flush > load.
- REQ-014: Load (freeze=0, flush=0): every *_out SHALL take its *_in value on the edge; valid_out SHALL become 1; latency exactly one cycle.
- REQ-015: Freeze=1: every output, including valid_out and flush_cnt, SHALL hold, regardless of flush.
- REQ-016: Flush=1 with freeze=0: all control outputs (WB_EN, MEM_R_EN, MEM_W_EN, B, S) and valid_out SHALL clear to 0, EXE_CMD_out to 0, all data fields to 0.
- REQ-017: A flush while freeze=1 SHALL be deferred (no state change); EXE holds the branch, so flush reasserts after freeze drops.
- REQ-018: flush_cnt SHALL increment by 1 on each applied flush and saturate at 16'hFFFF (no wrap).
- REQ-019: Back-to-back flushes SHALL each count and keep valid_out=0.
- REQ-020: SR_out SHALL be sampled under the same load/flush/freeze rules as other fields.
- REQ-021: No combinational path from any input to any output.
- REQ-022: A bubble (valid_out=0) SHALL never assert WB_EN_out, MEM_R_EN_out, MEM_W_EN_out, B_out or S_out.

Reset
- REQ-023: On rst=0 all outputs SHALL go to 0 immediately (asynchronous), including valid_out and flush_cnt.
- REQ-024: Reset assertion mid-freeze or mid-flush SHALL override both; the first edge after rst=1 SHALL apply normal priority.

Structure
- REQ-025: Shared package arm_pkg SHALL hold widths (EXE_CMD_W=4, REG_ADDR_W=4, SHIFT_OP_W=12, IMM24_W=24, SR_W=4) and the EXE_CMD encodings.
- REQ-026: One sub-module pipe_reg #(W) (async active-low reset, hold, clear, load) SHALL be instantiated per field; flush_cnt logic stays in the top.

Verification
- REQ-027: Reset released, inputs PC_in=32'h4, WB_EN_in=1, Dest_in=4'd3 -> after one edge PC_out=4, WB_EN_out=1, Dest_out=3, valid_out=1.
- REQ-028: Loaded state then freeze=1 for 3 cycles while inputs change to PC_in=32'h8 -> outputs stay at PC_out=4 throughout; after freeze drops, PC_out=8 next edge.
- REQ-029: flush=1 with MEM_W_EN_in=1, B_in=1 -> next edge all controls 0, valid_out=0, flush_cnt=1.
- REQ-030: flush=1 and freeze=1 together for 2 cycles -> no change, flush_cnt unchanged; then flush=1, freeze=0 -> bubble, flush_cnt+1.
- REQ-031: Force flush_cnt to 16'hFFFE, apply 3 flushes -> flush_cnt=16'hFFFF, no wrap.
- REQ-032: rst=0 asserted between edges during freeze -> all outputs 0 before the next edge; after rst=1 and one load edge valid_out=1.

Source files
------------

// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared widths and ALU command encodings for the ID/EXE pipeline
package arm_pkg;

    localparam int DATA_W     = 32;
    localparam int EXE_CMD_W  = 4;
    localparam int REG_ADDR_W = 4;
    localparam int SHIFT_OP_W = 12;
    localparam int IMM24_W    = 24;
    localparam int SR_W       = 4;
    localparam int CNT_W      = 16;

    // ALU commands; CMP/TST and LDR/STR alias the arithmetic ops they reuse
    localparam logic [EXE_CMD_W-1:0] EXE_NOP = 4'b0000;
    localparam logic [EXE_CMD_W-1:0] EXE_MOV = 4'b0001;
    localparam logic [EXE_CMD_W-1:0] EXE_MVN = 4'b1001;
    localparam logic [EXE_CMD_W-1:0] EXE_ADD = 4'b0010;
    localparam logic [EXE_CMD_W-1:0] EXE_ADC = 4'b0011;
    localparam logic [EXE_CMD_W-1:0] EXE_SUB = 4'b0100;
    localparam logic [EXE_CMD_W-1:0] EXE_SBC = 4'b0101;
    localparam logic [EXE_CMD_W-1:0] EXE_AND = 4'b0110;
    localparam logic [EXE_CMD_W-1:0] EXE_ORR = 4'b0111;
    localparam logic [EXE_CMD_W-1:0] EXE_EOR = 4'b1000;
    localparam logic [EXE_CMD_W-1:0] EXE_CMP = 4'b0100;
    localparam logic [EXE_CMD_W-1:0] EXE_TST = 4'b0110;
    localparam logic [EXE_CMD_W-1:0] EXE_LDR = 4'b0010;
    localparam logic [EXE_CMD_W-1:0] EXE_STR = 4'b0010;

endpackage

// File: rtl/pipe_reg.sv
// rtl/pipe_reg.sv - one pipeline field register with hold > clear > load priority
module pipe_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         hold_i,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q_q <= '0;
        else if (hold_i)
            q_q <= q_q;
        else if (clr_i)
            q_q <= '0;
        else
            q_q <= d_i;
    end

    assign q_o = q_q;

endmodule

// File: rtl/id_stage_reg.sv
// rtl/id_stage_reg.sv - ID/EXE pipeline register with freeze, flush-to-bubble and flush counter
module id_stage_reg
    import arm_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  freeze,
    input  logic                  WB_EN_in,
    input  logic                  MEM_R_EN_in,
    input  logic                  MEM_W_EN_in,
    input  logic                  B_in,
    input  logic                  S_in,
    input  logic [EXE_CMD_W-1:0]  EXE_CMD_in,
    input  logic [DATA_W-1:0]     PC_in,
    input  logic [DATA_W-1:0]     Val_Rn_in,
    input  logic [DATA_W-1:0]     Val_Rm_in,
    input  logic                  imm_in,
    input  logic [SHIFT_OP_W-1:0] Shift_operand_in,
    input  logic [IMM24_W-1:0]    Signed_imm_24_in,
    input  logic [REG_ADDR_W-1:0] Dest_in,
    input  logic [REG_ADDR_W-1:0] src1_in,
    input  logic [REG_ADDR_W-1:0] src2_in,
    input  logic [SR_W-1:0]       SR_in,
    output logic                  WB_EN_out,
    output logic                  MEM_R_EN_out,
    output logic                  MEM_W_EN_out,
    output logic                  B_out,
    output logic                  S_out,
    output logic [EXE_CMD_W-1:0]  EXE_CMD_out,
    output logic [DATA_W-1:0]     PC_out,
    output logic [DATA_W-1:0]     Val_Rn_out,
    output logic [DATA_W-1:0]     Val_Rm_out,
    output logic                  imm_out,
    output logic [SHIFT_OP_W-1:0] Shift_operand_out,
    output logic [IMM24_W-1:0]    Signed_imm_24_out,
    output logic [REG_ADDR_W-1:0] Dest_out,
    output logic [REG_ADDR_W-1:0] src1_out,
    output logic [REG_ADDR_W-1:0] src2_out,
    output logic [SR_W-1:0]       SR_out,
    output logic                  valid_out,
    output logic [CNT_W-1:0]      flush_cnt
);

    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d;

    pipe_reg #(.W(1)) u_wb_en (.clk(clk), .rst_n(rst), .hold_i(freeze), .clr_i(flush), .d_i(WB_EN_in), .q_o(WB_EN_out));
    pipe_reg #(.W(1)) u_mem_r (.clk(clk), .rst_n(rst), .hold_i(freeze), .clr_i(flush), .d_i(MEM_R_EN_in), .q_o(MEM_R_EN_out));
    pipe_reg #(.W(1)) u_mem_w (.clk(clk), .rst_n(rst), .hold_i(freeze), .clr_i(flush), .d_i(MEM_W_EN_in), .q_o(MEM_W_EN_out));
    pipe_reg #(.W(1)) u_b     (.clk(clk), .rst_n(rst), .hold_i(freeze), .clr_i(flush), .d_i(B_in), .q_o(B_out));
    pipe_reg #(.W(1)) u_s     (.clk(clk), .rst_n(rst), .hold_i(freeze), .clr_i(flush), .d_i(S_in), .q_o(S_out));
    pipe_reg #(.W(EXE_CMD_W)) u_exe_cmd (.clk(clk), .rst_n(rst), .hold_i(freeze), .clr_i(flush), .d_i(EXE_CMD_in), .q_o(EXE_CMD_out));
    pipe_reg #(.W(DATA_W)) u_pc     (.clk(clk), .rst_n(rst), .hold_i(freeze), .clr_i(flush), .d_i(PC_in), .q_o(PC_out));
    pipe_reg #(.W(DATA_W)) u_val_rn (.clk(clk), .rst_n(rst), .hold_i(freeze), .clr_i(flush), .d_i(Val_Rn_in), .q_o(Val_Rn_out));
    pipe_reg #(.W(DATA_W)) u_val_rm (.clk(clk), .rst_n(rst), .hold_i(freeze), .clr_i(flush), .d_i(Val_Rm_in), .q_o(Val_Rm_out));
    pipe_reg #(.W(1)) u_imm (.clk(clk), .rst_n(rst), .hold_i(freeze), .clr_i(flush), .d_i(imm_in), .q_o(imm_out));
    pipe_reg #(.W(SHIFT_OP_W)) u_shift (.clk(clk), .rst_n(rst), .hold_i(freeze), .clr_i(flush), .d_i(Shift_operand_in), .q_o(Shift_operand_out));
    pipe_reg #(.W(IMM24_W)) u_imm24 (.clk(clk), .rst_n(rst), .hold_i(freeze), .clr_i(flush), .d_i(Signed_imm_24_in), .q_o(Signed_imm_24_out));
    pipe_reg #(.W(REG_ADDR_W)) u_dest (.clk(clk), .rst_n(rst), .hold_i(freeze), .clr_i(flush), .d_i(Dest_in), .q_o(Dest_out));
    pipe_reg #(.W(REG_ADDR_W)) u_src1 (.clk(clk), .rst_n(rst), .hold_i(freeze), .clr_i(flush), .d_i(src1_in), .q_o(src1_out));
    pipe_reg #(.W(REG_ADDR_W)) u_src2 (.clk(clk), .rst_n(rst), .hold_i(freeze), .clr_i(flush), .d_i(src2_in), .q_o(src2_out));
    pipe_reg #(.W(SR_W)) u_sr (.clk(clk), .rst_n(rst), .hold_i(freeze), .clr_i(flush), .d_i(SR_in), .q_o(SR_out));

    // A load marks the slot real; a flush clears it to a bubble like every other field
    pipe_reg #(.W(1)) u_valid (.clk(clk), .rst_n(rst), .hold_i(freeze), .clr_i(flush), .d_i(1'b1), .q_o(valid_out));

    always_comb begin
        flush_cnt_d = flush_cnt_q;
        if (!freeze && flush && (flush_cnt_q != {CNT_W{1'b1}}))
            flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            flush_cnt_q <= '0;
        else
            flush_cnt_q <= flush_cnt_d;
    end

    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_id_stage_reg.sv
// tb/tb_id_stage_reg.sv - directed self-checking bench for id_stage_reg
module tb_id_stage_reg;

    logic        clk = 1'b0;
    logic        rst, flush, freeze;
    logic        WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, B_in, S_in, imm_in;
    logic [3:0]  EXE_CMD_in, Dest_in, src1_in, src2_in, SR_in;
    logic [31:0] PC_in, Val_Rn_in, Val_Rm_in;
    logic [11:0] Shift_operand_in;
    logic [23:0] Signed_imm_24_in;
    logic        WB_EN_out, MEM_R_EN_out, MEM_W_EN_out, B_out, S_out, imm_out, valid_out;
    logic [3:0]  EXE_CMD_out, Dest_out, src1_out, src2_out, SR_out;
    logic [31:0] PC_out, Val_Rn_out, Val_Rm_out;
    logic [11:0] Shift_operand_out;
    logic [23:0] Signed_imm_24_out;
    logic [15:0] flush_cnt;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    id_stage_reg dut (
        .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
        .WB_EN_in(WB_EN_in), .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in),
        .B_in(B_in), .S_in(S_in), .EXE_CMD_in(EXE_CMD_in), .PC_in(PC_in),
        .Val_Rn_in(Val_Rn_in), .Val_Rm_in(Val_Rm_in), .imm_in(imm_in),
        .Shift_operand_in(Shift_operand_in), .Signed_imm_24_in(Signed_imm_24_in),
        .Dest_in(Dest_in), .src1_in(src1_in), .src2_in(src2_in), .SR_in(SR_in),
        .WB_EN_out(WB_EN_out), .MEM_R_EN_out(MEM_R_EN_out), .MEM_W_EN_out(MEM_W_EN_out),
        .B_out(B_out), .S_out(S_out), .EXE_CMD_out(EXE_CMD_out), .PC_out(PC_out),
        .Val_Rn_out(Val_Rn_out), .Val_Rm_out(Val_Rm_out), .imm_out(imm_out),
        .Shift_operand_out(Shift_operand_out), .Signed_imm_24_out(Signed_imm_24_out),
        .Dest_out(Dest_out), .src1_out(src1_out), .src2_out(src2_out), .SR_out(SR_out),
        .valid_out(valid_out), .flush_cnt(flush_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ctrl_clear(input string tag);
        check({tag, " WB_EN"}, {31'd0, WB_EN_out}, 32'd0);
        check({tag, " MEM_R_EN"}, {31'd0, MEM_R_EN_out}, 32'd0);
        check({tag, " MEM_W_EN"}, {31'd0, MEM_W_EN_out}, 32'd0);
        check({tag, " B"}, {31'd0, B_out}, 32'd0);
        check({tag, " S"}, {31'd0, S_out}, 32'd0);
        check({tag, " valid"}, {31'd0, valid_out}, 32'd0);
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; freeze = 1'b0;
        WB_EN_in = 1'b0; MEM_R_EN_in = 1'b0; MEM_W_EN_in = 1'b0; B_in = 1'b0; S_in = 1'b0;
        imm_in = 1'b0; EXE_CMD_in = 4'h0; Dest_in = 4'h0; src1_in = 4'h0; src2_in = 4'h0;
        SR_in = 4'h0; PC_in = 32'h0; Val_Rn_in = 32'h0; Val_Rm_in = 32'h0;
        Shift_operand_in = 12'h0; Signed_imm_24_in = 24'h0;

        // reset state
        #2;
        check("reset PC", PC_out, 32'h0);
        check("reset flush_cnt", {16'd0, flush_cnt}, 32'h0);
        check_ctrl_clear("reset");

        // first load
        @(negedge clk);
        rst = 1'b1; PC_in = 32'h4; WB_EN_in = 1'b1; Dest_in = 4'd3;
        step();
        check("load PC", PC_out, 32'h4);
        check("load WB_EN", {31'd0, WB_EN_out}, 32'd1);
        check("load Dest", {28'd0, Dest_out}, 32'd3);
        check("load valid", {31'd0, valid_out}, 32'd1);

        // freeze holds for three edges while inputs move
        freeze = 1'b1; PC_in = 32'h8;
        for (int i = 0; i < 3; i++) begin
            step();
            check("freeze PC", PC_out, 32'h4);
            check("freeze valid", {31'd0, valid_out}, 32'd1);
        end
        freeze = 1'b0;
        step();
        check("unfreeze PC", PC_out, 32'h8);

        // flush produces a bubble
        flush = 1'b1; MEM_W_EN_in = 1'b1; B_in = 1'b1; S_in = 1'b1;
        step();
        check_ctrl_clear("flush1");
        check("flush1 PC", PC_out, 32'h0);
        check("flush1 Dest", {28'd0, Dest_out}, 32'd0);
        check("flush1 cnt", {16'd0, flush_cnt}, 32'd1);

        // back-to-back flush
        step();
        check_ctrl_clear("flush2");
        check("flush2 cnt", {16'd0, flush_cnt}, 32'd2);

        // reload, then flush deferred under freeze
        flush = 1'b0; MEM_W_EN_in = 1'b0; B_in = 1'b0; S_in = 1'b0; PC_in = 32'h10;
        step();
        check("reload PC", PC_out, 32'h10);
        check("reload valid", {31'd0, valid_out}, 32'd1);
        flush = 1'b1; freeze = 1'b1; PC_in = 32'h14;
        for (int i = 0; i < 2; i++) begin
            step();
            check("deferred PC", PC_out, 32'h10);
            check("deferred valid", {31'd0, valid_out}, 32'd1);
            check("deferred WB_EN", {31'd0, WB_EN_out}, 32'd1);
            check("deferred cnt", {16'd0, flush_cnt}, 32'd2);
        end
        freeze = 1'b0;
        step();
        check_ctrl_clear("flush3");
        check("flush3 cnt", {16'd0, flush_cnt}, 32'd3);

        // full-field load including SR
        flush = 1'b0; WB_EN_in = 1'b0; MEM_R_EN_in = 1'b1; S_in = 1'b1; imm_in = 1'b1;
        EXE_CMD_in = 4'b0100; PC_in = 32'hDEAD_BEEC; Val_Rn_in = 32'h1234_5678;
        Val_Rm_in = 32'hCAFE_F00D; Shift_operand_in = 12'hA5C; Signed_imm_24_in = 24'h80_0001;
        Dest_in = 4'hE; src1_in = 4'h7; src2_in = 4'h9; SR_in = 4'hA;
        step();
        check("full MEM_R_EN", {31'd0, MEM_R_EN_out}, 32'd1);
        check("full WB_EN", {31'd0, WB_EN_out}, 32'd0);
        check("full S", {31'd0, S_out}, 32'd1);
        check("full imm", {31'd0, imm_out}, 32'd1);
        check("full EXE_CMD", {28'd0, EXE_CMD_out}, 32'h4);
        check("full PC", PC_out, 32'hDEAD_BEEC);
        check("full Val_Rn", Val_Rn_out, 32'h1234_5678);
        check("full Val_Rm", Val_Rm_out, 32'hCAFE_F00D);
        check("full Shift", {20'd0, Shift_operand_out}, 32'hA5C);
        check("full Imm24", {8'd0, Signed_imm_24_out}, 32'h80_0001);
        check("full Dest", {28'd0, Dest_out}, 32'hE);
        check("full src1", {28'd0, src1_out}, 32'h7);
        check("full src2", {28'd0, src2_out}, 32'h9);
        check("full SR", {28'd0, SR_out}, 32'hA);

        // SR held by freeze, cleared by flush
        freeze = 1'b1; SR_in = 4'h5;
        step();
        check("freeze SR", {28'd0, SR_out}, 32'hA);
        freeze = 1'b0; flush = 1'b1;
        step();
        check("flush SR", {28'd0, SR_out}, 32'h0);
        check("flush EXE_CMD", {28'd0, EXE_CMD_out}, 32'h0);
        check("flush Val_Rn", Val_Rn_out, 32'h0);
        check("flush4 cnt", {16'd0, flush_cnt}, 32'd4);

        // saturation from a preset count
        freeze = 1'b1;
        step();
        force dut.flush_cnt_q = 16'hFFFE;
        #1;
        release dut.flush_cnt_q;
        #1;
        check("preset cnt", {16'd0, flush_cnt}, 32'h0000_FFFE);
        freeze = 1'b0;
        step();
        check("sat cnt1", {16'd0, flush_cnt}, 32'h0000_FFFF);
        step();
        check("sat cnt2", {16'd0, flush_cnt}, 32'h0000_FFFF);
        step();
        check("sat cnt3", {16'd0, flush_cnt}, 32'h0000_FFFF);

        // asynchronous reset between edges during freeze
        flush = 1'b0; PC_in = 32'h20;
        step();
        check("preload valid", {31'd0, valid_out}, 32'd1);
        freeze = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check("async PC", PC_out, 32'h0);
        check("async valid", {31'd0, valid_out}, 32'd0);
        check("async cnt", {16'd0, flush_cnt}, 32'd0);
        check("async MEM_R_EN", {31'd0, MEM_R_EN_out}, 32'd0);
        @(negedge clk);
        check("async held PC", PC_out, 32'h0);
        rst = 1'b1; freeze = 1'b0; PC_in = 32'h24;
        step();
        check("post-reset valid", {31'd0, valid_out}, 32'd1);
        check("post-reset PC", PC_out, 32'h24);
        check("post-reset cnt", {16'd0, flush_cnt}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
